// File: rtl/clk_activity_monitor.sv
// Samples a derived clock as data in the clk domain. It measures the rise-to-rise
// period, declares lock on a stable period and flags loss of toggling.
module clk_activity_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT     = 16,
    parameter int LOCK_COUNT  = 4,
    parameter int TOL         = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             mon_clk,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             lost,
    output logic [7:0]       err_count
);

    typedef enum logic [2:0] {
        ST_DISABLED,
        ST_ACQUIRE,
        ST_MEASURE,
        ST_LOCKED,
        ST_LOST
    } state_t;

    localparam int               MW        = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [31:0]      TOL_V     = 32'(TOL);
    localparam logic [MW-1:0]    LOCK_V    = MW'(LOCK_COUNT);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;
    logic                   w_s;
    logic                   w_rise;
    logic                   w_fall;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_per_cnt;
    logic [CNT_W-1:0]       r_idle_cnt;
    logic [CNT_W-1:0]       r_ref;
    logic                   r_have_ref;
    logic [MW-1:0]          r_match_cnt;
    logic [CNT_W-1:0]       r_period;
    logic                   r_rise_pulse;
    logic                   r_fall_pulse;
    logic                   r_period_valid;
    logic                   r_locked;
    logic                   r_lost;
    logic [7:0]             r_err_count;

    logic [CNT_W-1:0]       w_diff;
    logic                   w_match;
    logic                   w_timeout;
    logic [MW-1:0]          w_match_inc;
    logic                   w_lock_hit;

    // The synchroniser and edge register run regardless of en.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], mon_clk};
            r_sync_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_s         = r_sync[SYNC_STAGES-1];
    assign w_rise      = w_s & ~r_sync_d;
    assign w_fall      = ~w_s & r_sync_d;
    assign w_diff      = (r_per_cnt >= r_ref) ? (r_per_cnt - r_ref) : (r_ref - r_per_cnt);
    assign w_match     = (32'(w_diff) <= TOL_V);
    assign w_timeout   = (r_idle_cnt == TIMEOUT_V);
    assign w_match_inc = r_match_cnt + MW'(1);
    assign w_lock_hit  = (w_match_inc == LOCK_V);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state        <= ST_DISABLED;
            r_per_cnt      <= '0;
            r_idle_cnt     <= '0;
            r_ref          <= '0;
            r_have_ref     <= 1'b0;
            r_match_cnt    <= '0;
            r_period       <= '0;
            r_rise_pulse   <= 1'b0;
            r_fall_pulse   <= 1'b0;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_lost         <= 1'b0;
            r_err_count    <= '0;
        end else begin
            r_rise_pulse   <= w_rise & en;
            r_fall_pulse   <= w_fall & en;
            r_period_valid <= 1'b0;
            if (!en) begin
                // err_count survives a disable; only rstn clears it.
                r_state     <= ST_DISABLED;
                r_per_cnt   <= '0;
                r_idle_cnt  <= '0;
                r_ref       <= '0;
                r_have_ref  <= 1'b0;
                r_match_cnt <= '0;
                r_period    <= '0;
                r_locked    <= 1'b0;
                r_lost      <= 1'b0;
            end else begin
                if (w_rise)
                    r_per_cnt <= CNT_W'(1);
                else if (r_per_cnt != CNT_MAX)
                    r_per_cnt <= r_per_cnt + CNT_W'(1);

                if (w_rise || w_fall)
                    r_idle_cnt <= '0;
                else if (r_idle_cnt != CNT_MAX)
                    r_idle_cnt <= r_idle_cnt + CNT_W'(1);

                case (r_state)
                    ST_DISABLED: r_state <= ST_ACQUIRE;
                    ST_ACQUIRE, ST_LOST: begin
                        // A rise here only opens a fresh measurement window.
                        if (w_rise) begin
                            r_state     <= ST_MEASURE;
                            r_have_ref  <= 1'b0;
                            r_match_cnt <= '0;
                            r_lost      <= 1'b0;
                        end else if (w_timeout) begin
                            r_state <= ST_LOST;
                            r_lost  <= 1'b1;
                        end
                    end
                    ST_MEASURE: begin
                        if (w_rise) begin
                            r_period       <= r_per_cnt;
                            r_period_valid <= 1'b1;
                            r_ref          <= r_per_cnt;
                            r_have_ref     <= 1'b1;
                            if (r_have_ref) begin
                                if (w_match) begin
                                    r_match_cnt <= w_match_inc;
                                    if (w_lock_hit) begin
                                        r_state  <= ST_LOCKED;
                                        r_locked <= 1'b1;
                                    end
                                end else begin
                                    r_match_cnt <= '0;
                                end
                            end
                        end else if (w_timeout) begin
                            r_state <= ST_LOST;
                            r_lost  <= 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_rise) begin
                            r_period       <= r_per_cnt;
                            r_period_valid <= 1'b1;
                            r_ref          <= r_per_cnt;
                            if (!w_match) begin
                                r_state     <= ST_MEASURE;
                                r_locked    <= 1'b0;
                                r_match_cnt <= '0;
                                if (r_err_count != 8'hFF)
                                    r_err_count <= r_err_count + 8'd1;
                            end
                        end else if (w_timeout) begin
                            r_state  <= ST_LOST;
                            r_locked <= 1'b0;
                            r_lost   <= 1'b1;
                        end
                    end
                    default: r_state <= ST_DISABLED;
                endcase
            end
        end
    end

    assign rise_pulse   = r_rise_pulse;
    assign fall_pulse   = r_fall_pulse;
    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign locked       = r_locked;
    assign lost         = r_lost;
    assign err_count    = r_err_count;

endmodule
